// File: rtl/tone_sample_gen_if.sv
// rtl/tone_sample_gen_if.sv - sample handshake bundle between tone generator and codec
`timescale 1ns/1ps

interface tone_sample_gen_if;
  logic        sampleValid;
  logic [15:0] sampleData;
  logic        sampleReady;

  modport master (output sampleValid, output sampleData, input sampleReady);
  modport slave  (input sampleValid, input sampleData, output sampleReady);
endinterface

// File: rtl/tone_sample_gen.sv
// rtl/tone_sample_gen.sv - square-wave tone to signed audio samples with valid/ready hold
// Optional envelope ramping when TONE_SAMPLE_FADE_EN is defined.
`timescale 1ns/1ps

module tone_sample_gen #(
  parameter logic [15:0] AMP_BASE  = 16'h0400,
  parameter logic [15:0] RAMP_STEP = 16'h0010
) (
  input  logic                     inClk,
  input  logic                     reset_n,
  input  logic                     toneIn,
  input  logic                     enable,
  input  logic [2:0]               volume,
  input  logic                     sampleTick,
  output logic                     overrun,
  tone_sample_gen_if.master        smp
);

  typedef enum logic {IDLE, HOLD} state_t;

`ifdef TONE_SAMPLE_FADE_EN
  localparam logic [15:0] STEP = RAMP_STEP;
`else
  // An all-ones step always reaches the clamp, so env jumps straight to goal.
  localparam logic [15:0] STEP = RAMP_STEP | 16'hFFFF;
`endif

  state_t      state;
  logic        tone_meta;
  logic        tone_sync;
  logic [15:0] env;
  logic [15:0] data_q;
  logic        valid_q;
  logic        overrun_q;

  logic [18:0] target_wide;
  logic [15:0] target;
  logic [15:0] goal;
  logic [15:0] next_env;
  logic [15:0] sample;

  always_comb begin
    target_wide = 19'(AMP_BASE) * 19'({1'b0, volume} + 4'd1);
    target      = (target_wide > 19'h07FFF) ? 16'h7FFF : target_wide[15:0];
    goal        = enable ? target : 16'h0000;
    sample      = tone_sync ? env : (16'h0000 - env);
  end

  // Move toward goal by at most STEP, landing exactly on goal without overshoot.
  always_comb begin
    next_env = goal;
    if (goal > env) begin
      if ((goal - env) > STEP) next_env = env + STEP;
    end else if (env > goal) begin
      if ((env - goal) > STEP) next_env = env - STEP;
    end
  end

  always_ff @(posedge inClk or negedge reset_n) begin
    if (!reset_n) begin
      tone_meta <= 1'b0;
      tone_sync <= 1'b0;
    end else begin
      tone_meta <= toneIn;
      tone_sync <= tone_meta;
    end
  end

  always_ff @(posedge inClk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      valid_q   <= 1'b0;
      data_q    <= 16'h0000;
      overrun_q <= 1'b0;
      env       <= 16'h0000;
    end else begin
      if (sampleTick) env <= next_env;
      case (state)
        IDLE: begin
          if (sampleTick) begin
            data_q  <= sample;
            valid_q <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (smp.sampleReady) begin
            if (sampleTick) begin
              data_q <= sample;
            end else begin
              valid_q <= 1'b0;
              state   <= IDLE;
            end
          end else if (sampleTick) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign smp.sampleValid = valid_q;
  assign smp.sampleData  = data_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_tone_sample_gen.sv
// tb/tb_tone_sample_gen.sv - self-checking bench for tone_sample_gen with a behavioural model
`timescale 1ns/1ps

module tb_tone_sample_gen;

  localparam int AMP  = 'h0400;
  localparam int STEP = 'h0010;

  logic       inClk = 1'b0;
  logic       reset_n = 1'b0;
  logic       toneIn = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] volume = 3'd0;
  logic       sampleTick = 1'b0;
  logic       overrun;

  tone_sample_gen_if bus ();

  tone_sample_gen dut (
    .inClk      (inClk),
    .reset_n    (reset_n),
    .toneIn     (toneIn),
    .enable     (enable),
    .volume     (volume),
    .sampleTick (sampleTick),
    .overrun    (overrun),
    .smp        (bus)
  );

  always #10 inClk = ~inClk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int         env_m;
  bit         pend_m;
  logic [15:0] data_m;
  bit         ovr_m;
  bit         s1, s2;

  function automatic void model_clear();
    env_m = 0; pend_m = 0; data_m = 16'h0000; ovr_m = 0; s1 = 0; s2 = 0;
  endfunction

  function automatic void model_edge();
    int t;
    int gl;
    logic [15:0] smpv;
    t = AMP * (int'(volume) + 1);
    if (t > 32767) t = 32767;
    gl = enable ? t : 0;
    if (sampleTick) begin
      smpv = s2 ? 16'(env_m) : 16'(-env_m);
      if (!pend_m) begin
        data_m = smpv;
        pend_m = 1;
      end else if (bus.sampleReady) begin
        data_m = smpv;
      end else begin
        ovr_m = 1;
      end
`ifdef TONE_SAMPLE_FADE_EN
      if (env_m < gl) env_m = (gl - env_m > STEP) ? env_m + STEP : gl;
      else if (env_m > gl) env_m = (env_m - gl > STEP) ? env_m - STEP : gl;
`else
      env_m = gl;
`endif
    end else if (pend_m && bus.sampleReady) begin
      pend_m = 0;
    end
    s2 = s1;
    s1 = toneIn;
  endfunction

  task automatic cycle(input bit tk, input bit rd);
    @(negedge inClk);
    sampleTick = tk;
    bus.sampleReady = rd;
    @(posedge inClk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge inClk);
    #2 reset_n = 1'b0;
    sampleTick = 1'b0;
    bus.sampleReady = 1'b0;
    repeat (2) @(posedge inClk);
    model_clear();
    @(negedge inClk);
    reset_n = 1'b1;
  endtask

  task automatic settle();
    repeat (3) cycle(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (bus.sampleValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.sampleValid); end
    checks++;
    if (bus.sampleData !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", bus.sampleData); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b want 0", overrun); end
  endtask

  task automatic test_basic_pulse();
    logic [15:0] exp2;
`ifdef TONE_SAMPLE_FADE_EN
    exp2 = 16'h0010;
`else
    exp2 = 16'h0400;
`endif
    do_reset();
    enable = 1'b1; volume = 3'd0; toneIn = 1'b1;
    settle();
    cycle(1'b1, 1'b1);
    checks++;
    if (bus.sampleValid !== 1'b1 || bus.sampleData !== 16'h0000) begin
      errors++; $display("FAIL first_tick valid %0b data %h want 1 0000", bus.sampleValid, bus.sampleData);
    end
    cycle(1'b0, 1'b1);
    checks++;
    if (bus.sampleValid !== 1'b0) begin errors++; $display("FAIL valid_pulse got %0b want 0", bus.sampleValid); end
    cycle(1'b1, 1'b1);
    checks++;
    if (bus.sampleValid !== 1'b1 || bus.sampleData !== exp2) begin
      errors++; $display("FAIL second_tick valid %0b data %h want 1 %h", bus.sampleValid, bus.sampleData, exp2);
    end
  endtask

  task automatic test_negative();
    logic [15:0] exp;
`ifdef TONE_SAMPLE_FADE_EN
    exp = 16'hFFF0;
`else
    exp = 16'hE000;
`endif
    do_reset();
    enable = 1'b1; volume = 3'd7; toneIn = 1'b0;
    settle();
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    checks++;
    if (bus.sampleData !== exp) begin errors++; $display("FAIL negative_sample got %h want %h", bus.sampleData, exp); end
  endtask

  task automatic test_overrun();
    logic [15:0] first;
`ifdef TONE_SAMPLE_FADE_EN
    first = 16'h0010;
`else
    first = 16'h0C00;
`endif
    do_reset();
    enable = 1'b1; volume = 3'd2; toneIn = 1'b1;
    settle();
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    checks++;
    if (overrun !== 1'b0 || bus.sampleData !== first) begin
      errors++; $display("FAIL ovr_tick1 ovr %0b data %h want 0 %h", overrun, bus.sampleData, first);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0);
      checks++;
      if (overrun !== 1'b1 || bus.sampleValid !== 1'b1 || bus.sampleData !== first) begin
        errors++; $display("FAIL ovr_hold%0d ovr %0b valid %0b data %h want 1 1 %h", i, overrun, bus.sampleValid, bus.sampleData, first);
      end
    end
    cycle(1'b0, 1'b0);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %0b want 1", overrun); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
`ifdef TONE_SAMPLE_FADE_EN
    exp = 16'hFFE0;
`else
    exp = 16'hF800;
`endif
    do_reset();
    enable = 1'b1; volume = 3'd1; toneIn = 1'b1;
    settle();
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    toneIn = 1'b0;
    settle();
    cycle(1'b1, 1'b1);
    checks++;
    if (bus.sampleValid !== 1'b1 || bus.sampleData !== exp || overrun !== 1'b0) begin
      errors++; $display("FAIL same_cycle valid %0b data %h ovr %0b want 1 %h 0", bus.sampleValid, bus.sampleData, overrun, exp);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0);
    checks++;
    if (overrun !== 1'b1 || bus.sampleValid !== 1'b1) begin
      errors++; $display("FAIL pre_reset ovr %0b valid %0b want 1 1", overrun, bus.sampleValid);
    end
    @(negedge inClk);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.sampleValid !== 1'b0 || bus.sampleData !== 16'h0000 || overrun !== 1'b0) begin
      errors++; $display("FAIL async_reset valid %0b data %h ovr %0b want 0 0000 0", bus.sampleValid, bus.sampleData, overrun);
    end
    sampleTick = 1'b0;
    bus.sampleReady = 1'b0;
    @(posedge inClk);
    model_clear();
    @(negedge inClk);
    reset_n = 1'b1;
    toneIn = 1'b1;
    settle();
    cycle(1'b1, 1'b0);
    checks++;
    if (bus.sampleValid !== 1'b1 || bus.sampleData !== 16'h0000 || overrun !== 1'b0) begin
      errors++; $display("FAIL post_reset_tick valid %0b data %h ovr %0b want 1 0000 0", bus.sampleValid, bus.sampleData, overrun);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset();
      if ($urandom_range(7) == 0) toneIn = ~toneIn;
      if ($urandom_range(31) == 0) enable = $urandom_range(1);
      if ($urandom_range(31) == 0) volume = 3'($urandom_range(7));
      cycle($urandom_range(3) == 0, 1'($urandom_range(1)));
      checks++;
      if (bus.sampleValid !== pend_m || bus.sampleData !== data_m || overrun !== ovr_m) begin
        errors++;
        $display("FAIL random_%0d valid %0b data %h ovr %0b want %0b %h %0b",
                 i, bus.sampleValid, bus.sampleData, overrun, pend_m, data_m, ovr_m);
      end
    end
  endtask

`ifdef TONE_SAMPLE_FADE_EN
  task automatic test_fade();
    int e;
    do_reset();
    enable = 1'b1; volume = 3'd0; toneIn = 1'b1;
    settle();
    for (int i = 1; i <= 70; i++) begin
      cycle(1'b1, 1'b1);
      e = STEP * (i - 1);
      if (e > AMP) e = AMP;
      checks++;
      if (bus.sampleData !== 16'(e)) begin errors++; $display("FAIL fade_up_%0d got %h want %h", i, bus.sampleData, 16'(e)); end
      cycle(1'b0, 1'b1);
    end
    enable = 1'b0;
    for (int j = 1; j <= 66; j++) begin
      cycle(1'b1, 1'b1);
      e = AMP - STEP * (j - 1);
      if (e < 0) e = 0;
      checks++;
      if (bus.sampleData !== 16'(e)) begin errors++; $display("FAIL fade_down_%0d got %h want %h", j, bus.sampleData, 16'(e)); end
      cycle(1'b0, 1'b1);
    end
  endtask
`endif

  initial begin
    bus.sampleReady = 1'b0;
    model_clear();
    test_reset();
    test_basic_pulse();
    test_negative();
    test_overrun();
    test_back_to_back();
    test_async_reset();
`ifdef TONE_SAMPLE_FADE_EN
    test_fade();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
